// File: rtl/k_counter_if.sv
// Handshake bundle between the DPLL phase detector side and the K-counter loop filter.
// The master drives the tick/error/modulus inputs; the slave returns the pulses and lock status.
interface k_counter_if;
  logic       en;
  logic       dn_up;
  logic [3:0] k_mod;
  logic       inc;
  logic       dec;
  logic       lock;

  modport master (
    output en,
    output dn_up,
    output k_mod,
    input  inc,
    input  dec,
    input  lock
  );

  modport slave (
    input  en,
    input  dn_up,
    input  k_mod,
    output inc,
    output dec,
    output lock
  );
endinterface

// File: rtl/k_counter.sv
// Random-walk K-counter loop filter: modulo-K up/down integrators emitting inc/dec pulses,
// plus a windowed net-pulse measurement that drives a registered lock flag.
module k_counter #(
  parameter int K_WIDTH   = 8,
  parameter int WIN_WIDTH = 10,
  parameter int LOCK_TOL  = 2
) (
  input  logic        clk,
  input  logic        reset,
  k_counter_if.slave  bus
);

  localparam int KA_W  = $clog2(K_WIDTH + 1);
  localparam int NET_W = WIN_WIDTH + 2;

  localparam logic [31:0]             KW_U    = K_WIDTH;
  localparam logic [K_WIDTH:0]        ONE_K   = (K_WIDTH + 1)'(1);
  localparam logic signed [NET_W-1:0] NET_MAX = {1'b0, {(NET_W-1){1'b1}}};
  localparam logic signed [NET_W-1:0] NET_MIN = {1'b1, {(NET_W-1){1'b0}}};
  localparam logic signed [NET_W-1:0] TOL_P   = NET_W'(LOCK_TOL);
  localparam logic signed [NET_W-1:0] TOL_N   = -TOL_P;

  logic [KA_W-1:0]         k_act;
  logic [KA_W-1:0]         k_act_nxt;
  logic [K_WIDTH:0]        k_full;
  logic [K_WIDTH-1:0]      k_lim;
  logic [K_WIDTH-1:0]      up_cnt;
  logic [K_WIDTH-1:0]      dn_cnt;
  logic [WIN_WIDTH-1:0]    win_cnt;
  logic signed [NET_W-1:0] net;
  logic signed [NET_W-1:0] delta;
  logic signed [NET_W-1:0] net_sat;
  logic                    up_term;
  logic                    dn_term;
  logic                    win_end;
  logic                    net_ok;
  logic                    inc_r;
  logic                    dec_r;
  logic                    lock_r;

  always_comb begin
    k_act_nxt = KA_W'(K_WIDTH);
    if (bus.k_mod < 4'd2) begin
      k_act_nxt = KA_W'(2);
    end else if (32'(bus.k_mod) > KW_U) begin
      k_act_nxt = KA_W'(K_WIDTH);
    end else begin
      k_act_nxt = KA_W'(bus.k_mod);
    end
  end

  // Terminal uses >= so shrinking the modulus wraps an over-range count on its next tick.
  assign k_full  = (ONE_K << k_act) - ONE_K;
  assign k_lim   = k_full[K_WIDTH-1:0];
  assign up_term = bus.en & ~bus.dn_up & (up_cnt >= k_lim);
  assign dn_term = bus.en &  bus.dn_up & (dn_cnt >= k_lim);
  assign win_end = bus.en & (&win_cnt);

  always_comb begin
    delta = '0;
    if (inc_r) begin
      delta = NET_W'(1);
    end else if (dec_r) begin
      delta = '1;
    end
  end

  always_comb begin
    net_sat = net + delta;
    if (inc_r && (net == NET_MAX)) begin
      net_sat = net;
    end else if (dec_r && (net == NET_MIN)) begin
      net_sat = net;
    end
  end

  assign net_ok = (net <= TOL_P) && (net >= TOL_N);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_act   <= KA_W'(K_WIDTH);
      up_cnt  <= '0;
      dn_cnt  <= '0;
      win_cnt <= '0;
      net     <= '0;
      inc_r   <= 1'b0;
      dec_r   <= 1'b0;
      lock_r  <= 1'b0;
    end else begin
      k_act <= k_act_nxt;
      if (bus.en && !bus.dn_up) begin
        up_cnt <= up_term ? '0 : up_cnt + K_WIDTH'(1);
      end
      if (bus.en && bus.dn_up) begin
        dn_cnt <= dn_term ? '0 : dn_cnt + K_WIDTH'(1);
      end
      inc_r <= up_term;
      dec_r <= dn_term;
      if (bus.en) begin
        win_cnt <= win_cnt + WIN_WIDTH'(1);
      end
      // A pulse coinciding with the window end seeds the next window rather than closing this one.
      if (win_end) begin
        lock_r <= net_ok;
        net    <= delta;
      end else begin
        net    <= net_sat;
      end
    end
  end

  assign bus.inc  = inc_r;
  assign bus.dec  = dec_r;
  assign bus.lock = lock_r;

endmodule
